dm_arbiter: RTL

DM_ARBITER -- requirements
Module: dm_arbiter

---
 rtl/dm_arb_pkg.sv | 16 +
 rtl/dm_arb_starve_cnt.sv | 40 ++++
 rtl/dm_arbiter.sv | 127 ++++++++++++
 3 files changed

// File: rtl/dm_arb_pkg.sv
// Shared encodings and default constants for the data-memory arbiter.
package dm_arb_pkg;

    localparam int DEF_DMA_SIZE     = 16;
    localparam int DEF_DMD_SIZE     = 16;
    localparam int DEF_STARVE_LIMIT = 8;
    localparam int CNT_W            = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CORE  = 2'd1,
        DMA   = 2'd2,
        FORCE = 2'd3
    } arb_state_t;

endpackage

// File: rtl/dm_arb_starve_cnt.sv
// Starvation counter: counts core-won cycles while DMA waits, saturating at limit.
module dm_arb_starve_cnt
    import dm_arb_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    input  logic [CNT_W-1:0] limit,
    output logic             hit
);

    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;

    // Next count: clear wins, otherwise increment until saturated at limit.
    always_comb begin
        cnt_nxt_s = cnt_r;
        if (clr) begin
            cnt_nxt_s = {CNT_W{1'b0}};
        end else if (inc && (cnt_r != limit)) begin
            cnt_nxt_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_nxt_s = cnt_r;
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_r <= {CNT_W{1'b0}};
        end else begin
            cnt_r <= cnt_nxt_s;
        end
    end

    // hit looks at the next value so FORCE is entered in the following cycle.
    assign hit = (cnt_nxt_s == limit);

endmodule

// File: rtl/dm_arbiter.sv
// Core/DMA data-memory arbiter with core priority.
// Starvation protection (counter, FORCE state, arb_stallb) only with DM_ARB_STARVE_PROTECT_EN.
module dm_arbiter
    import dm_arb_pkg::*;
#(
    parameter int DMA_SIZE     = DEF_DMA_SIZE,
    parameter int DMD_SIZE     = DEF_DMD_SIZE,
    parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                ps_dm_cslt,
    input  logic                ps_dm_wrb,
    input  logic [DMA_SIZE-1:0] dg_dm_add,
    input  logic [DMD_SIZE-1:0] bc_dt,
    input  logic                dma_req,
    input  logic                dma_wrb,
    input  logic [DMA_SIZE-1:0] dma_add,
    input  logic [DMD_SIZE-1:0] dma_wdt,
    output logic                arb_dm_cslt,
    output logic                arb_dm_wrb,
    output logic [DMA_SIZE-1:0] arb_dm_add,
    output logic [DMD_SIZE-1:0] arb_dm_wdt,
    input  logic [DMD_SIZE-1:0] dm_arb_dt,
    output logic                dma_gnt,
    output logic                dma_rvalid,
    output logic [DMD_SIZE-1:0] dma_rdata,
    output logic                arb_stallb
);

    arb_state_t state_r;
    logic       force_s;
    logic       go_force_s;
    logic       core_gnt_s;
    logic       dma_gnt_s;
    logic       rvalid_r;

`ifdef DM_ARB_STARVE_PROTECT_EN
    logic hit_s;
    logic stallb_r;

    dm_arb_starve_cnt u_starve_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (dma_req && core_gnt_s),
        .clr   (dma_gnt_s || !dma_req),
        .limit (CNT_W'(STARVE_LIMIT)),
        .hit   (hit_s)
    );

    assign force_s    = (state_r == FORCE);
    assign go_force_s = hit_s && dma_req && !force_s;
    assign arb_stallb = stallb_r;

    // One-cycle core stall coinciding with the FORCE cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stallb_r <= 1'b1;
        end else begin
            stallb_r <= !go_force_s;
        end
    end
`else
    assign force_s    = 1'b0;
    assign go_force_s = 1'b0;
    assign arb_stallb = 1'b1;
`endif

    // Grant decision; nothing is granted while reset is held.
    always_comb begin
        core_gnt_s = 1'b0;
        dma_gnt_s  = 1'b0;
        if (reset) begin
            core_gnt_s = 1'b0;
            dma_gnt_s  = 1'b0;
        end else begin
            core_gnt_s = ps_dm_cslt && !force_s;
            dma_gnt_s  = dma_req && (!ps_dm_cslt || force_s);
        end
    end

    // Memory-side mux of the granted requester's fields.
    always_comb begin
        arb_dm_cslt = 1'b0;
        arb_dm_wrb  = 1'b1;
        arb_dm_add  = {DMA_SIZE{1'b0}};
        arb_dm_wdt  = {DMD_SIZE{1'b0}};
        if (core_gnt_s) begin
            arb_dm_cslt = 1'b1;
            arb_dm_wrb  = ps_dm_wrb;
            arb_dm_add  = dg_dm_add;
            arb_dm_wdt  = bc_dt;
        end else if (dma_gnt_s) begin
            arb_dm_cslt = 1'b1;
            arb_dm_wrb  = dma_wrb;
            arb_dm_add  = dma_add;
            arb_dm_wdt  = dma_wdt;
        end else begin
            arb_dm_cslt = 1'b0;
            arb_dm_wrb  = 1'b1;
        end
    end

    // Arbitration state and DMA read-return flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r  <= IDLE;
            rvalid_r <= 1'b0;
        end else begin
            rvalid_r <= dma_gnt_s && dma_wrb;
            if (go_force_s) begin
                state_r <= FORCE;
            end else if (ps_dm_cslt) begin
                state_r <= CORE;
            end else if (dma_req) begin
                state_r <= DMA;
            end else begin
                state_r <= IDLE;
            end
        end
    end

    assign dma_gnt    = dma_gnt_s;
    assign dma_rvalid = rvalid_r;
    assign dma_rdata  = rvalid_r ? dm_arb_dt : {DMD_SIZE{1'b0}};

endmodule
